// File: rtl/clock_period_meter_if.sv
// rtl/clock_period_meter_if.sv - measurement control/result bundle for clock_period_meter
interface clock_period_meter_if #(
    parameter int W = 16
);
    logic         slow_in;
    logic         start;
    logic         cont;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         valid;
    logic         busy;
    logic         timeout;

    modport master (
        output slow_in, start, cont,
        input  period, high_time, valid, busy, timeout
    );

    modport slave (
        input  slow_in, start, cont,
        output period, high_time, valid, busy, timeout
    );
endinterface

// File: rtl/clock_period_meter.sv
// rtl/clock_period_meter.sv - measures period and high time of a slow clock in clk cycles
module clock_period_meter #(
    parameter int W    = 16,
    parameter int SYNC = 2
) (
    input  logic                  clk,
    input  logic                  RESET,
    clock_period_meter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    state_t          r_state;
    state_t          w_next;
    logic [SYNC-1:0] r_sync;
    logic            r_s_d;
    logic [W-1:0]    r_cnt;
    logic [W-1:0]    r_hcnt;
    logic [W-1:0]    r_period;
    logic [W-1:0]    r_high;
    logic            r_timeout;
    logic            w_s;
    logic            w_rise;
    logic            w_sat;
    logic [W-1:0]    w_s_ext;

    assign w_s     = r_sync[SYNC-1];
    assign w_rise  = w_s & ~r_s_d;
    assign w_sat   = (r_cnt == CNT_MAX);
    assign w_s_ext = {{(W-1){1'b0}}, w_s};

    always_ff @(posedge clk) begin
        if (!RESET) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC-2:0], bus.slow_in};
            r_s_d  <= w_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!RESET) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // A rise always wins over saturation, so a window ending exactly at the limit still completes.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start && !r_timeout) w_next = ARM;
            ARM:     if (w_rise) w_next = MEASURE;
                     else if (w_sat) w_next = IDLE;
            MEASURE: if (w_rise) w_next = DONE;
                     else if (w_sat) w_next = IDLE;
            DONE:    w_next = bus.cont ? MEASURE : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // The terminating rise opens the next window at count 1; DONE keeps counting so
    // back-to-back windows lose no cycles.
    always_ff @(posedge clk) begin
        if (!RESET) begin
            r_cnt     <= '0;
            r_hcnt    <= '0;
            r_period  <= '0;
            r_high    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_next == ARM) begin
                        r_cnt  <= '0;
                        r_hcnt <= '0;
                    end
                end
                ARM: begin
                    if (w_rise) begin
                        r_cnt  <= CNT_ONE;
                        r_hcnt <= CNT_ONE;
                    end else if (w_sat) begin
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                MEASURE: begin
                    if (w_rise) begin
                        r_period <= r_cnt;
                        r_high   <= r_hcnt;
                        r_cnt    <= CNT_ONE;
                        r_hcnt   <= CNT_ONE;
                    end else if (w_sat) begin
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt  <= r_cnt + CNT_ONE;
                        r_hcnt <= r_hcnt + w_s_ext;
                    end
                end
                DONE: begin
                    r_cnt  <= r_cnt + CNT_ONE;
                    r_hcnt <= r_hcnt + w_s_ext;
                end
                default: begin
                    r_cnt  <= '0;
                    r_hcnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        bus.valid = 1'b0;
        bus.busy  = 1'b0;
        if (r_state == DONE) bus.valid = 1'b1;
        if (r_state != IDLE) bus.busy  = 1'b1;
    end

    assign bus.period    = r_period;
    assign bus.high_time = r_high;
    assign bus.timeout   = r_timeout;
endmodule

// File: tb/tb_clock_period_meter.sv
// tb/tb_clock_period_meter.sv - scoreboard bench for clock_period_meter
module tb_clock_period_meter;
    typedef struct {
        bit kind;
        int per;
        int hi;
    } exp_t;

    logic clk = 1'b0;
    logic RESET = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q16[$];
    exp_t q4[$];

    bit gen_on = 1'b0;
    int gen_p = 32;
    int gen_h = 16;
    int phase = 0;

    clock_period_meter_if #(.W(16)) b16();
    clock_period_meter_if #(.W(4))  b4();

    clock_period_meter #(.W(16), .SYNC(2)) u16 (.clk(clk), .RESET(RESET), .bus(b16));
    clock_period_meter #(.W(4),  .SYNC(2)) u4  (.clk(clk), .RESET(RESET), .bus(b4));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    always @(posedge clk) begin
        #1;
        if (gen_on) begin
            b16.slow_in = (phase < gen_h);
            phase = (phase + 1 == gen_p) ? 0 : phase + 1;
        end else begin
            b16.slow_in = 1'b0;
            phase = 0;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (b16.valid === 1'b1 || b16.timeout === 1'b1) begin
            if (q16.size() == 0) begin
                chk("sb16_unexpected_output", 1, 0);
            end else begin
                e = q16.pop_front();
                chk("sb16_kind", int'(b16.timeout), int'(e.kind));
                chk("sb16_period", int'(b16.period), e.per);
                chk("sb16_high_time", int'(b16.high_time), e.hi);
            end
        end
        if (b4.valid === 1'b1 || b4.timeout === 1'b1) begin
            if (q4.size() == 0) begin
                chk("sb4_unexpected_output", 1, 0);
            end else begin
                e = q4.pop_front();
                chk("sb4_kind", int'(b4.timeout), int'(e.kind));
                chk("sb4_period", int'(b4.period), e.per);
                chk("sb4_high_time", int'(b4.high_time), e.hi);
            end
        end
    end

    task automatic push16(input int per, input int hi);
        exp_t e;
        e.kind = 1'b0; e.per = per; e.hi = hi;
        q16.push_back(e);
    endtask

    task automatic wait_valid16(input int max, input string nm);
        int n = 0;
        do begin @(negedge clk); n++; end while (b16.valid !== 1'b1 && n < max);
        if (b16.valid !== 1'b1) tmo(nm);
    endtask

    task automatic wait_busy16(input string nm);
        int n = 0;
        do begin @(negedge clk); n++; end while (b16.busy !== 1'b1 && n < 10);
        if (b16.busy !== 1'b1) tmo(nm);
    endtask

    task automatic pulse_start16;
        @(posedge clk); #1 b16.start = 1'b1;
        @(posedge clk); #1 b16.start = 1'b0;
    endtask

    initial begin
        int n;
        int t_arm;
        bit busy_ok;
        bit prev;
        exp_t e;
        b16.start = 1'b0; b16.cont = 1'b0;
        b4.start = 1'b0; b4.cont = 1'b0; b4.slow_in = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_period", int'(b16.period), 0);
        chk("rst_high_time", int'(b16.high_time), 0);
        chk("rst_valid", int'(b16.valid), 0);
        chk("rst_busy", int'(b16.busy), 0);
        chk("rst_timeout", int'(b16.timeout), 0);
        chk("rst_busy_w4", int'(b4.busy), 0);

        // start honored on the first active cycle, then a 50% duty clk/32 window
        push16(32, 16);
        @(posedge clk); #1 RESET = 1'b1; b16.start = 1'b1;
        @(posedge clk); #1 b16.start = 1'b0; gen_on = 1'b1;
        @(negedge clk);
        chk("start_after_reset_busy", int'(b16.busy), 1);
        wait_valid16(200, "wait_valid_50pct");
        chk("busy_at_valid", int'(b16.busy), 1);
        @(negedge clk);
        chk("busy_falls_after_valid", int'(b16.busy), 0);

        // continuous mode, four windows
        repeat (4) push16(32, 16);
        @(posedge clk); #1 b16.cont = 1'b1;
        pulse_start16();
        wait_valid16(200, "wait_valid_cont_first");
        busy_ok = 1'b1;
        for (int w = 1; w < 4; w++) begin
            n = 0;
            do begin
                @(negedge clk); n++;
                if (b16.busy !== 1'b1) busy_ok = 1'b0;
            end while (b16.valid !== 1'b1 && n < 100);
            chk("cont_valid_interval", n, 32);
        end
        b16.cont = 1'b0;
        chk("cont_busy_held", int'(busy_ok), 1);
        @(negedge clk);
        chk("cont_busy_falls", int'(b16.busy), 0);

        // skewed duty: period 20, high 5
        @(posedge clk); #1 gen_on = 1'b0;
        repeat (2) @(posedge clk);
        #1 gen_p = 20; gen_h = 5; gen_on = 1'b1;
        repeat (50) @(posedge clk);
        push16(20, 5);
        pulse_start16();
        wait_valid16(200, "wait_valid_skewed");

        // start re-pulsed in ARM/MEASURE and in DONE is ignored
        push16(20, 5);
        pulse_start16();
        wait_busy16("wait_busy_ignored_start");
        n = 0;
        while (b16.valid !== 1'b1 && n < 100) begin
            b16.start = n[0];
            @(negedge clk);
            n++;
        end
        if (b16.valid !== 1'b1) tmo("wait_valid_ignored_start");
        b16.start = 1'b1;
        @(posedge clk); #1 b16.start = 1'b0;
        @(negedge clk);
        chk("no_rearm_after_done", int'(b16.busy), 0);
        busy_ok = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (b16.busy !== 1'b0) busy_ok = 1'b0;
        end
        chk("stays_idle_after_ignored_start", int'(busy_ok), 1);

        // reset asserted in MEASURE
        chk("period_before_reset", int'(b16.period), 20);
        pulse_start16();
        wait_busy16("wait_busy_reset_case");
        prev = b16.slow_in;
        n = 0;
        do begin
            @(negedge clk); n++;
            if (b16.slow_in === 1'b1 && prev == 1'b0) break;
            prev = b16.slow_in;
        end while (n < 60);
        if (n >= 60) tmo("wait_slow_rise");
        repeat (5) @(negedge clk);
        RESET = 1'b0;
        @(posedge clk); #1 RESET = 1'b1;
        @(negedge clk);
        chk("mreset_period", int'(b16.period), 0);
        chk("mreset_high_time", int'(b16.high_time), 0);
        chk("mreset_valid", int'(b16.valid), 0);
        chk("mreset_busy", int'(b16.busy), 0);
        chk("mreset_timeout", int'(b16.timeout), 0);
        busy_ok = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (b16.busy !== 1'b0) busy_ok = 1'b0;
        end
        chk("mreset_stays_idle", int'(busy_ok), 1);

        // timeout with W=4 and slow_in tied low
        e.kind = 1'b1; e.per = 0; e.hi = 0;
        q4.push_back(e);
        @(posedge clk); #1 b4.start = 1'b1;
        @(posedge clk); #1 b4.start = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (b4.busy !== 1'b1 && n < 10);
        if (b4.busy !== 1'b1) tmo("wait_busy_w4");
        t_arm = cyc;
        n = 0;
        do begin @(negedge clk); n++; end while (b4.timeout !== 1'b1 && n < 40);
        if (b4.timeout !== 1'b1) tmo("wait_timeout_w4");
        chk("timeout_latency", cyc - t_arm, 16);
        chk("timeout_state_idle", int'(b4.busy), 0);
        b4.start = 1'b1;
        @(posedge clk); #1 b4.start = 1'b0;
        @(negedge clk);
        chk("start_with_timeout_ignored", int'(b4.busy), 0);
        chk("timeout_single_pulse", int'(b4.timeout), 0);

        repeat (10) @(negedge clk);
        chk("sb16_drained", q16.size(), 0);
        chk("sb4_drained", q4.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
